reservation_station: RTL
========================

# reservation_station

Holds up to eight decoded instructions after the instruction queue has issued them. Each entry waits until both source operands are available, capturing missing operands from the common data bus (CDB). The entry then dispatches to the ALU in lowest-index-first order. The block sits between the instruction queue/register-rename stage and the ALU, and it drives the `rs_full` back-pressure signal that the instruction queue samples.

## Interface

**Parameters**
- `ENTRIES`, default 8: number of station slots; must be a power of two, at least 4.
- `TAG_W`, default 4: ROB tag width.
- `FULL_MARGIN`, default 2: number of free slots reserved as skid for instructions already in flight from the instruction queue.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear on branch mispredict.
- `op_in` in 5: issued opcode; `5'b11111` means no instruction this cycle.
- `vj_in` in 32: value of operand j, valid when `qj_valid_in`=0.
- `qj_valid_in` in 1: operand j is pending on tag `qj_in`.
- `qj_in` in TAG_W: producer tag for operand j.
- `vk_in` in 32, `qk_valid_in` in 1, `qk_in` in TAG_W: same as the three j ports, for operand k.
- `imm_in` in 32: immediate value.
- `has_imm_in` in 1: when 1, operand b is `imm_in` and operand k is treated as ready.
- `dest_in` in TAG_W: ROB tag of the instruction.
- `cdb_valid` in 1: CDB broadcast is valid.
- `cdb_tag` in TAG_W: tag of the broadcast result.
- `cdb_value` in 32: value of the broadcast result.
- `alu_busy` in 1: ALU cannot accept an instruction this cycle.
- `rs_full` out 1: back-pressure to the instruction queue.
- `exec_valid` out 1: dispatch outputs are valid this cycle.
- `op_out` out 5: dispatched opcode; `5'b11111` when idle.
- `a_out` out 32: operand a.
- `b_out` out 32: operand b.
- `dest_out` out TAG_W: ROB tag of the dispatched instruction.
- `count` out clog2(ENTRIES)+1: number of occupied slots.
- `overflow` out 1: sticky error flag.

## Operation

**Entry contents**
- `busy`, `op`, `vj`, `qj_valid`, `qj`, `vk`, `qk_valid`, `qk`, `dest`.
- For an immediate instruction, `vk` holds `imm_in` and `qk_valid` is 0.
- An entry is ready when `busy`=1, `qj_valid`=0 and `qk_valid`=0.

**Allocation**
- When `op_in` is not `5'b11111`, write the instruction into the lowest-index slot that is not busy.
- Slots freed on the same edge are not reused on that edge.
- Allocation bypass: if `cdb_valid` is high and `cdb_tag` equals a pending incoming tag, store `cdb_value` and clear that operand's pending flag at allocation.

**Wakeup**
- On every edge with `cdb_valid` high, each busy entry compares `cdb_tag` against `qj` and `qk`.
- On a match, the entry latches `cdb_value` into the matching operand and clears its pending flag.
- Both operands may match in the same cycle.

**Dispatch**
- When `alu_busy`=0, select the lowest-index entry that was ready before the edge.
- Register its `op`, `vj`, `vk` and `dest` into `op_out`, `a_out`, `b_out` and `dest_out`, set `exec_valid`=1, and clear that entry's `busy`.
- If no entry is ready, or `alu_busy`=1, drive `exec_valid`=0 and `op_out`=`5'b11111`. The other dispatch outputs hold their previous values.

**Occupancy**
- `count` increases by 1 for an allocation and decreases by 1 for a dispatch; when both happen on the same edge it is unchanged.
- `rs_full` is registered: `rs_full` = (next `count` ≥ `ENTRIES` − `FULL_MARGIN`).

**Overflow**
- If an instruction arrives while all slots are busy, drop it and set `overflow`=1.
- `overflow` stays set until reset.

**Flush and reset**
- `flush` clears every `busy` bit and zeroes `count`, `rs_full` and `exec_valid`, and sets `op_out`=`5'b11111`.
- `flush` takes priority over allocation and dispatch on the same edge.
- `overflow` is not cleared by `flush`.
- Asynchronous `rst` applies the same clears as `flush` and also clears `overflow`, `a_out`, `b_out` and `dest_out`.

## Timing

**Reset values**
- `rs_full`=0, `exec_valid`=0, `op_out`=`5'b11111`.
- `a_out`=0, `b_out`=0, `dest_out`=0, `count`=0, `overflow`=0.

**Latencies**
- Allocation to earliest dispatch: 1 cycle. An instruction allocated with both operands ready at edge N can appear on `exec_valid` at edge N+1, never at edge N.
- CDB wakeup at edge N makes the entry eligible for dispatch selection at edge N+1.
- Bypass at allocation behaves the same as wakeup: an instruction allocated at edge N with a same-cycle CDB match is also eligible at edge N+1.
- `exec_valid` is a one-cycle pulse per dispatched instruction. Back-to-back dispatches on consecutive cycles are allowed.

**Back-pressure**
- `rs_full` is valid one cycle after the `count` change that causes it.
- The instruction queue may still deliver up to `FULL_MARGIN` instructions after `rs_full` rises; these must be accepted without overflow.

**Mid-operation reset**
- An `rst` pulse in the middle of operation returns all outputs to their reset values immediately.
- The first allocation after reset uses slot 0.

## Test plan

1. **Ready instruction:** reset, then one instruction with `op_in`=3, `vj`=5, `vk`=7 and both ready → at the next edge `exec_valid`=1, `op_out`=3, `a_out`=5, `b_out`=7; `count` goes 1 → 0.
2. **CDB wakeup:** instruction with `qj_valid`=1, `qj`=4; hold for 3 cycles with no dispatch; then `cdb_valid`=1, `cdb_tag`=4, `cdb_value`=`32'hDEAD` → dispatch one cycle later with `a_out`=`32'hDEAD`.
3. **Allocation bypass and immediate:** issue with `qj`=2 pending and `has_imm_in`=1, `imm_in`=`-1`, while the CDB broadcasts tag 2 value 9 in the same cycle → next cycle `a_out`=9, `b_out`=`32'hFFFFFFFF`.
4. **Fill and back-pressure:** issue 6 non-ready instructions → `rs_full` rises one cycle after the 6th; issue 2 more → `count`=8 and `overflow`=0; a 9th instruction → `overflow`=1 and `count` stays 8.
5. **Priority and `alu_busy`:** slots 0 and 2 both ready while `alu_busy`=1 → `exec_valid`=0; release `alu_busy` → slot 0 dispatches, then slot 2 on the following cycle.
6. **Flush vs. simultaneous events:** `flush` asserted on the same edge as an allocation and a CDB broadcast → `count`=0, `exec_valid`=0, `op_out`=`5'b11111`. Asserting `rst` asynchronously between edges immediately clears all outputs.

Source files
------------

// File: rtl/reservation_station_if.sv
// Issue, CDB, ALU-dispatch and status signals of the reservation station.
// The station takes the slave modport; whoever drives it takes the master modport.
interface reservation_station_if #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4
);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  // Handshakes: an issue is "valid" when op_in != 5'b11111 and is taken on that
  // edge (there is no ready); rs_full is advisory back-pressure that leaves
  // FULL_MARGIN slots of skid. Dispatch is valid when exec_valid=1 for one cycle
  // and is only produced on edges where alu_busy (the inverse of ready) was 0.
  logic             flush;
  logic [4:0]       op_in;
  logic [31:0]      vj_in;
  logic             qj_valid_in;
  logic [TAG_W-1:0] qj_in;
  logic [31:0]      vk_in;
  logic             qk_valid_in;
  logic [TAG_W-1:0] qk_in;
  logic [31:0]      imm_in;
  logic             has_imm_in;
  logic [TAG_W-1:0] dest_in;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             alu_busy;
  logic             rs_full;
  logic             exec_valid;
  logic [4:0]       op_out;
  logic [31:0]      a_out;
  logic [31:0]      b_out;
  logic [TAG_W-1:0] dest_out;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output flush, op_in, vj_in, qj_valid_in, qj_in, vk_in, qk_valid_in, qk_in,
           imm_in, has_imm_in, dest_in, cdb_valid, cdb_tag, cdb_value, alu_busy,
    input  rs_full, exec_valid, op_out, a_out, b_out, dest_out, count, overflow
  );

  modport slave (
    input  flush, op_in, vj_in, qj_valid_in, qj_in, vk_in, qk_valid_in, qk_in,
           imm_in, has_imm_in, dest_in, cdb_valid, cdb_tag, cdb_value, alu_busy,
    output rs_full, exec_valid, op_out, a_out, b_out, dest_out, count, overflow
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds issued instructions until both operands are known,
// snoops the CDB for missing operands and dispatches lowest-index-first to the ALU.
module reservation_station #(
  parameter int ENTRIES     = 8,
  parameter int TAG_W       = 4,
  parameter int FULL_MARGIN = 2
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [4:0]       NOP     = 5'b11111;
  localparam logic [CNT_W-1:0] FULL_AT = CNT_W'(ENTRIES - FULL_MARGIN);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] qj_valid;
  logic [ENTRIES-1:0] qk_valid;
  logic [4:0]         op_q   [ENTRIES];
  logic [31:0]        vj_q   [ENTRIES];
  logic [31:0]        vk_q   [ENTRIES];
  logic [TAG_W-1:0]   qj_q   [ENTRIES];
  logic [TAG_W-1:0]   qk_q   [ENTRIES];
  logic [TAG_W-1:0]   dest_q [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] busy_next;
  logic               ready_any, disp_en;
  logic               free_any, alloc_req, alloc_en, overflow_evt;
  logic [IDX_W-1:0]   disp_idx, free_idx;
  logic [CNT_W-1:0]   count_next;
  logic               alloc_qjv, alloc_qkv;
  logic [31:0]        alloc_vj, alloc_vk;

  // Readiness and free slots are judged on pre-edge state, so a slot freed by
  // dispatch is not reused on the same edge and a fresh entry waits one cycle.
  assign ready        = busy & ~qj_valid & ~qk_valid;
  assign alloc_req    = (rs.op_in != NOP);
  assign disp_en      = ready_any & ~rs.alu_busy;
  assign alloc_en     = alloc_req & free_any;
  assign overflow_evt = alloc_req & ~free_any;

  always_comb begin
    ready_any = 1'b0;
    disp_idx  = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        ready_any = 1'b1;
        disp_idx  = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_next = busy;
    if (disp_en)  busy_next[disp_idx] = 1'b0;
    if (alloc_en) busy_next[free_idx] = 1'b1;
    count_next = rs.count;
    if (alloc_en && !disp_en)      count_next = rs.count + CNT_W'(1);
    else if (!alloc_en && disp_en) count_next = rs.count - CNT_W'(1);
  end

  // Operands for a newly allocated entry, including same-cycle CDB bypass.
  always_comb begin
    alloc_qjv = rs.qj_valid_in;
    alloc_vj  = rs.vj_in;
    if (rs.qj_valid_in && rs.cdb_valid && (rs.cdb_tag == rs.qj_in)) begin
      alloc_qjv = 1'b0;
      alloc_vj  = rs.cdb_value;
    end
    alloc_qkv = rs.qk_valid_in;
    alloc_vk  = rs.vk_in;
    if (rs.has_imm_in) begin
      alloc_qkv = 1'b0;
      alloc_vk  = rs.imm_in;
    end else if (rs.qk_valid_in && rs.cdb_valid && (rs.cdb_tag == rs.qk_in)) begin
      alloc_qkv = 1'b0;
      alloc_vk  = rs.cdb_value;
    end
  end

  // Payload needs no reset: nothing is looked at unless busy is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_en && (free_idx == IDX_W'(i))) begin
        op_q[i]     <= rs.op_in;
        vj_q[i]     <= alloc_vj;
        vk_q[i]     <= alloc_vk;
        qj_q[i]     <= rs.qj_in;
        qk_q[i]     <= rs.qk_in;
        dest_q[i]   <= rs.dest_in;
        qj_valid[i] <= alloc_qjv;
        qk_valid[i] <= alloc_qkv;
      end else if (rs.cdb_valid && busy[i]) begin
        if (qj_valid[i] && (qj_q[i] == rs.cdb_tag)) begin
          vj_q[i]     <= rs.cdb_value;
          qj_valid[i] <= 1'b0;
        end
        if (qk_valid[i] && (qk_q[i] == rs.cdb_tag)) begin
          vk_q[i]     <= rs.cdb_value;
          qk_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= '0;
      rs.count      <= '0;
      rs.rs_full    <= 1'b0;
      rs.exec_valid <= 1'b0;
      rs.op_out     <= NOP;
      rs.a_out      <= '0;
      rs.b_out      <= '0;
      rs.dest_out   <= '0;
      rs.overflow   <= 1'b0;
    end else if (rs.flush) begin
      busy          <= '0;
      rs.count      <= '0;
      rs.rs_full    <= 1'b0;
      rs.exec_valid <= 1'b0;
      rs.op_out     <= NOP;
    end else begin
      busy          <= busy_next;
      rs.count      <= count_next;
      rs.rs_full    <= (count_next >= FULL_AT);
      rs.exec_valid <= disp_en;
      if (overflow_evt) rs.overflow <= 1'b1;
      if (disp_en) begin
        rs.op_out   <= op_q[disp_idx];
        rs.a_out    <= vj_q[disp_idx];
        rs.b_out    <= vk_q[disp_idx];
        rs.dest_out <= dest_q[disp_idx];
      end else begin
        rs.op_out   <= NOP;
      end
    end
  end
endmodule
